demux_1x8_tdm: RTL and testbench
================================

// Module: demux_1x8_tdm
// PURPOSE
//   Time-division demultiplexer: the receive end of the 8:1 select-mux link.
//   A frame of SLOTS words arrives one word per enabled cycle on din, slot 0
//   marked by frame_sync. Slots are collected in a shadow register. A complete
//   frame is then published in parallel on dout with a one-cycle frame_valid strobe.
//   Slot i maps to mux input i+1 (select code i, s1 = MSB).
// PARAMETERS
//   SLOTS  8  slots per frame; power of 2, >= 2
//   WIDTH  1  bits per slot word
//   CW     $clog2(SLOTS)  slot counter width (localparam, not overridable)
// PORTS
//   clk          in   1            rising-edge clock
//   rst_n        in   1            asynchronous reset, active low
//   en           in   1            din/frame_sync are sampled only when high
//   frame_sync   in   1            high with the slot-0 word of a frame
//   din          in   WIDTH        serial slot word
//   dout         out  SLOTS*WIDTH  last complete frame; slot i at [i*WIDTH +: WIDTH]
//   frame_valid  out  1            one-cycle pulse: dout just updated
//   locked       out  1            1 = aligned to frame
//   slot_idx     out  CW           slot index the next enabled word is written to
//   sync_err     out  1            only with DEMUX_SYNC_ERR_EN; tied 0 otherwise
// BEHAVIOUR
//   Reset (async, any time): dout=0, frame_valid=0, locked=0, slot_idx=0,
//     sync_err=0, shadow=0, state=HUNT. A partial frame is discarded.
//   FSM with 2 states. All updates happen on a clk edge with en=1. en=0 freezes
//     all state. frame_valid and sync_err read 0 in any cycle after an en=0 edge.
//   HUNT: din is ignored unless frame_sync=1. On an edge with frame_sync=1:
//     shadow[0]=din, slot_idx=1, locked=1, go to LOCKED.
//   LOCKED, frame_sync=0: shadow[slot_idx]=din, slot_idx++.
//   LOCKED, frame_sync=1 and slot_idx==0: normal frame start, handled as above.
//   LOCKED, frame_sync=1 and slot_idx!=0: resync.
//     - The partial frame is dropped and dout is unchanged.
//     - shadow[0]=din and slot_idx=1.
//   Frame completion, on the edge that writes slot SLOTS-1:
//     - dout = shadow with that slot included.
//     - frame_valid=1 for exactly the next cycle.
//     - slot_idx wraps to 0. No resync is needed for back-to-back frames.
//   Latency: last slot sampled at edge N; dout and frame_valid are valid after edge N.
//   If frame_sync is missing at slot_idx==0, the stream is accepted as slot 0 (flywheel).
//     The FSM stays LOCKED.
//   Only reset returns the FSM to HUNT.
//   dout holds between frames. It is never partially updated.
// CONFIGURATION
//   DEMUX_SYNC_ERR_EN defined:
//     - sync_err pulses high for one cycle after each resync edge.
//     - sync_err pulses high for one cycle after a LOCKED edge with slot_idx==0 and frame_sync=0.
//   DEMUX_SYNC_ERR_EN undefined: no detection logic. sync_err is held at 0.
//   All other behaviour is identical in both builds.
// TESTING
//   1 Reset: assert rst_n=0 mid-frame, with no clk edge.
//     -> dout=0, frame_valid=0, locked=0, slot_idx=0 immediately.
//   2 HUNT: en=1, din toggling, frame_sync=0, for 20 cycles.
//     -> locked=0, frame_valid never 1, dout=0.
//   3 Frame: sync plus 8 words, slot i = pattern 0,1,0,1,1,0,1,0.
//     -> after the 8th edge: dout=8'b01011010, frame_valid=1 for exactly 1 cycle.
//   4 en gaps: same frame as test 3, with en=0 for 3 cycles between slots 3 and 4.
//     -> identical dout. slot_idx holds at 4 during the gap.
//   5 Resync: frame_sync at slot_idx=5, followed by 8 words of 8'hFF.
//     -> no frame_valid for the partial frame. Then dout=8'hFF.
//     -> sync_err=1 for 1 cycle when DEMUX_SYNC_ERR_EN is defined, else 0.
//   6 Back-to-back frames A=8'h3C, B=8'hC3 with no en gaps.
//     -> frame_valid pulses exactly 8 cycles apart. dout=8'h3C, then 8'hC3.

Source files
------------

// File: rtl/demux_1x8_tdm.sv
// Receive end of the 8:1 TDM link: collects one slot word per enabled cycle and
// publishes whole frames on dout. Define DEMUX_SYNC_ERR_EN to enable sync_err.
module demux_1x8_tdm #(
   parameter  int SLOTS = 8,
   parameter  int WIDTH = 1,
   localparam int CW    = $clog2(SLOTS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   frame_sync,
   input  logic [WIDTH-1:0]       din,
   output logic [SLOTS*WIDTH-1:0] dout,
   output logic                   frame_valid,
   output logic                   locked,
   output logic [CW-1:0]          slot_idx,
   output logic                   sync_err
);

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam logic [CW-1:0] LAST_SLOT = CW'(SLOTS - 1);

   state_t                 state, state_nxt;
   logic [CW-1:0]          slot_nxt;
   logic [SLOTS*WIDTH-1:0] shadow, shadow_nxt;
   logic [SLOTS*WIDTH-1:0] dout_nxt;
   logic                   fv_nxt;
`ifdef DEMUX_SYNC_ERR_EN
   logic                   err_nxt;
   logic                   err_q;
`endif

   always_comb begin
      state_nxt  = state;
      slot_nxt   = slot_idx;
      shadow_nxt = shadow;
      dout_nxt   = dout;
      fv_nxt     = 1'b0;
`ifdef DEMUX_SYNC_ERR_EN
      err_nxt    = 1'b0;
`endif
      if (en) begin
         unique case (state)
            HUNT: begin
               if (frame_sync) begin
                  shadow_nxt[WIDTH-1:0] = din;
                  slot_nxt              = CW'(1);
                  state_nxt             = LOCKED;
               end
            end
            LOCKED: begin
               if (frame_sync) begin
                  // sync mid-frame drops the partial frame; dout is left untouched
                  shadow_nxt[WIDTH-1:0] = din;
                  slot_nxt              = CW'(1);
`ifdef DEMUX_SYNC_ERR_EN
                  err_nxt               = (slot_idx != '0);
`endif
               end else begin
                  for (int unsigned i = 0; i < SLOTS; i++) begin
                     if (slot_idx == CW'(i)) shadow_nxt[i*WIDTH +: WIDTH] = din;
                  end
                  slot_nxt = slot_idx + 1'b1;
                  if (slot_idx == LAST_SLOT) begin
                     dout_nxt = shadow_nxt;
                     fv_nxt   = 1'b1;
                  end
`ifdef DEMUX_SYNC_ERR_EN
                  err_nxt = (slot_idx == '0);
`endif
               end
            end
            default: state_nxt = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= HUNT;
         slot_idx    <= '0;
         shadow      <= '0;
         dout        <= '0;
         frame_valid <= 1'b0;
      end else begin
         state       <= state_nxt;
         slot_idx    <= slot_nxt;
         shadow      <= shadow_nxt;
         dout        <= dout_nxt;
         frame_valid <= fv_nxt;
      end
   end

`ifdef DEMUX_SYNC_ERR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_nxt;
   end
   assign sync_err = err_q;
`else
   assign sync_err = 1'b0;
`endif

   assign locked = (state == LOCKED);

endmodule

// File: tb/tb_demux_1x8_tdm.sv
// Directed table-driven bench for demux_1x8_tdm (8 slots x 1 bit); expects
// sync_err pulses only when DEMUX_SYNC_ERR_EN is defined.
module tb_demux_1x8_tdm;

`ifdef DEMUX_SYNC_ERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       frame_sync = 1'b0;
   logic [0:0] din = 1'b0;
   logic [7:0] dout;
   logic       frame_valid;
   logic       locked;
   logic [2:0] slot_idx;
   logic       sync_err;

   always #5 clk = ~clk;

   demux_1x8_tdm #(.SLOTS(8), .WIDTH(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .frame_sync (frame_sync),
      .din        (din),
      .dout       (dout),
      .frame_valid(frame_valid),
      .locked     (locked),
      .slot_idx   (slot_idx),
      .sync_err   (sync_err)
   );

   typedef struct {
      string      tag;
      logic       en;
      logic       fs;
      logic       din;
      logic [7:0] dout;
      logic       fv;
      logic       lk;
      logic [2:0] slot;
      logic       err;
   } vec_t;

   vec_t        vecs[$];
   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;

   function automatic void add(string tag, logic en_v, logic fs_v, logic din_v,
                               logic [7:0] d, logic fv, logic lk, logic [2:0] s, logic err);
      vec_t v;
      v.tag = tag; v.en = en_v; v.fs = fs_v; v.din = din_v;
      v.dout = d; v.fv = fv; v.lk = lk; v.slot = s; v.err = err;
      vecs.push_back(v);
   endfunction

   // whole frame from slot index 0, slot i carrying word[i]
   function automatic void add_frame(string tag, logic [7:0] word, logic sync0,
                                     logic [7:0] prev, logic err0);
      for (int i = 0; i < 8; i++)
         add(tag, 1'b1, sync0 && (i == 0), word[i], (i == 7) ? word : prev,
             (i == 7), 1'b1, 3'((i + 1) % 8), (i == 0) ? err0 : 1'b0);
   endfunction

   task automatic chk(string tag, string field, logic [7:0] act, logic [7:0] exp);
      if (act !== exp) begin
         $display("FAIL %s.%s: got %h expected %h", tag, field, act, exp);
         n_miss++;
      end
   endtask

   task automatic check_outs(vec_t v);
      n_vec++;
      chk(v.tag, "dout",        dout,        v.dout);
      chk(v.tag, "frame_valid", frame_valid, v.fv);
      chk(v.tag, "locked",      locked,      v.lk);
      chk(v.tag, "slot_idx",    slot_idx,    v.slot);
      chk(v.tag, "sync_err",    sync_err,    v.err);
   endtask

   task automatic apply(vec_t v);
      @(negedge clk);
      en         = v.en;
      frame_sync = v.fs;
      din        = v.din;
      @(posedge clk);
      #1;
      check_outs(v);
   endtask

   initial begin
      logic [7:0] w;
      vec_t       h;
      w = 8'h5A;

      for (int i = 0; i < 20; i++)
         add("hunt", 1'b1, 1'b0, 1'(i % 2), 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
      add_frame("frame", 8'h5A, 1'b1, 8'h00, 1'b0);
      add("fv_drop", 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 3'd0, 1'b0);

      for (int i = 0; i < 4; i++)
         add("gap_a", 1'b1, (i == 0), w[i], 8'h5A, 1'b0, 1'b1, 3'(i + 1), 1'b0);
      for (int j = 0; j < 3; j++)
         add("gap_hold", 1'b0, 1'b1, 1'(j % 2), 8'h5A, 1'b0, 1'b1, 3'd4, 1'b0);
      for (int i = 4; i < 8; i++)
         add("gap_b", 1'b1, 1'b0, w[i], 8'h5A, (i == 7), 1'b1, 3'((i + 1) % 8), 1'b0);
      add("fv_drop2", 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 3'd0, 1'b0);

      for (int i = 0; i < 5; i++)
         add("partial", 1'b1, (i == 0), 1'b0, 8'h5A, 1'b0, 1'b1, 3'(i + 1), 1'b0);
      add("resync", 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 3'd1, ERR_EN);
      for (int i = 1; i < 8; i++)
         add("ff", 1'b1, 1'b0, 1'b1, (i == 7) ? 8'hFF : 8'h5A, (i == 7), 1'b1,
             3'((i + 1) % 8), 1'b0);

      add_frame("frA", 8'h3C, 1'b1, 8'hFF, 1'b0);
      add_frame("frB", 8'hC3, 1'b1, 8'h3C, 1'b0);
      add_frame("fly", 8'hA5, 1'b0, 8'hC3, ERR_EN);
      add("idle", 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 3'd0, 1'b0);

      #1;
      h.tag = "por"; h.dout = 8'h00; h.fv = 1'b0; h.lk = 1'b0; h.slot = 3'd0; h.err = 1'b0;
      check_outs(h);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[k]) apply(vecs[k]);

      // start a frame, then pull reset asynchronously mid-frame
      h.tag = "pre_rst"; h.en = 1'b1; h.fs = 1'b1; h.din = 1'b1;
      h.dout = 8'hA5; h.fv = 1'b0; h.lk = 1'b1; h.slot = 3'd1; h.err = 1'b0;
      apply(h);
      h.fs = 1'b0; h.slot = 3'd2;
      apply(h);
      h.slot = 3'd3;
      apply(h);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      h.tag = "async_rst"; h.dout = 8'h00; h.lk = 1'b0; h.slot = 3'd0; h.fv = 1'b0; h.err = 1'b0;
      check_outs(h);
      @(negedge clk);
      rst_n = 1'b1;

      h.tag = "post_rst_hunt"; h.en = 1'b1; h.fs = 1'b0; h.din = 1'b1;
      apply(h);
      h.tag = "relock"; h.fs = 1'b1; h.lk = 1'b1; h.slot = 3'd1;
      apply(h);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
